// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode/function constants, instruction format and loader state encodings
// for the instruction encoder/loader and its packer.
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNC_SLL  = 6'b000000;
    localparam logic [5:0] FUNC_MUL  = 6'b000010;
    localparam logic [5:0] FUNC_SRL  = 6'b000010;
    localparam logic [5:0] FUNC_SRA  = 6'b000011;
    localparam logic [5:0] FUNC_SLLV = 6'b000100;
    localparam logic [5:0] FUNC_SRLV = 6'b000110;
    localparam logic [5:0] FUNC_SRAV = 6'b000111;
    localparam logic [5:0] FUNC_JR   = 6'b001000;
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

    // INIT is the one-cycle post-reset state in which the loader is not yet ready.
    typedef enum logic [2:0] {INIT, ACCEPT, WRITE, FILL, DONE} state_t;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: selects the R/I/J format from op/func, packs the fields
// into a 32-bit MIPS word and flags whether the op/func pair is supported.
module instr_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    fmt_t fmt;

    // mul lives under its own opcode but uses the R layout.
    always_comb begin
        fmt = FMT_I;
        if (op == OP_RTYPE || (op == OP_MUL && func == FUNC_MUL)) begin
            fmt = FMT_R;
        end else if (op == OP_J || op == OP_JAL) begin
            fmt = FMT_J;
        end
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
                    FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
                    FUNC_SLT, FUNC_SLTU, FUNC_SLL, FUNC_SRL,
                    FUNC_SRA, FUNC_SLLV, FUNC_SRLV, FUNC_SRAV,
                    FUNC_JR: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_MUL: legal = (func == FUNC_MUL);
            OP_J, OP_JAL,
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_SLTI, OP_SLTIU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R:   word = {op, rs, rt, rd, shamt, func};
            FMT_J:   word = {op, target};
            default: word = {op, rs, rt, imm};
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field beats, packs them and writes IMEM
// sequentially while holding the CPU. Optional LOADER_ZERO_FILL_EN pads IMEM with nops.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_next, tail_state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word_r;
    logic              last_r;
    logic [31:0]       pk_word;
    logic              pk_legal;
    logic [ADDR_W:0]   count_inc;

    instr_packer u_packer (
        .op     (in_op),
        .func   (in_func),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (pk_word),
        .legal  (pk_legal)
    );

    // Where a finished (but not full) program goes next.
`ifdef LOADER_ZERO_FILL_EN
    assign tail_state = FILL;
`else
    assign tail_state = DONE;
`endif

    assign count_inc = count + 1'b1;
    assign imem_addr = ptr;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_wdata = '0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        case (state)
            INIT: state_next = ACCEPT;
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (pk_legal) begin
                        state_next = WRITE;
                    end else if (in_last) begin
                        state_next = tail_state;
                    end
                end
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_wdata = word_r;
                if (count_inc == DEPTH_C) begin
                    state_next = DONE;
                end else if (last_r) begin
                    state_next = tail_state;
                end else begin
                    state_next = ACCEPT;
                end
            end
            FILL: begin
                imem_we = 1'b1;
                if (count_inc == DEPTH_C) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            default: state_next = INIT;
        endcase
    end

    // Illegal beats only raise the sticky flag; the pointer moves on writes alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            ptr         <= '0;
            count       <= '0;
            word_r      <= '0;
            last_r      <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ACCEPT && in_valid) begin
                if (pk_legal) begin
                    word_r <= pk_word;
                    last_r <= in_last;
                end else begin
                    err_illegal <= 1'b1;
                end
            end
            if (imem_we) begin
                ptr   <= ptr + 1'b1;
                count <= count_inc;
            end
        end
    end

endmodule
